// File: rtl/elevator_pkg.sv
// Shared types and floor helpers for the elevator car scheduler.
package elevator_pkg;

  localparam int unsigned N_FLOORS = 5;
  localparam int unsigned FLOOR_W = 4;
  localparam logic [FLOOR_W-1:0] FLOOR_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  typedef logic [N_FLOORS-1:0] floor_vec_t;
  typedef logic [FLOOR_W-1:0]  floor_t;

  // Bit i of every floor vector stands for floor i+1.
  function automatic floor_vec_t floor_onehot(input floor_t f);
    floor_vec_t v;
    v = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++)
      if (f == floor_t'(i + 1)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic floor_vec_t above_mask(input floor_t f);
    floor_vec_t v;
    v = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++)
      if (floor_t'(i + 1) > f) v[i] = 1'b1;
    return v;
  endfunction

  function automatic floor_vec_t below_mask(input floor_t f);
    floor_vec_t v;
    v = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++)
      if (floor_t'(i + 1) < f) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/elevator_if.sv
// Call/status bundle between the call panels (master) and the car scheduler (slave).
//   call_req  : one-cycle call pulses, bit i = floor i+1
//   pending   : outstanding calls
//   cur_floor : car floor 1..5
//   dir_up, moving, door_open, arrive : car status
interface elevator_if;
  import elevator_pkg::*;

  floor_vec_t call_req;
  floor_vec_t pending;
  floor_t     cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic       arrive;

  modport master (
    output call_req,
    input  pending, cur_floor, dir_up, moving, door_open, arrive
  );

  modport slave (
    input  call_req,
    output pending, cur_floor, dir_up, moving, door_open, arrive
  );

endinterface

// File: rtl/elevator_timer.sv
// Load/decrement down-counter with zero flag; holds at zero.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (has priority over decrement)
//   zero       : counter currently zero
module elevator_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_controller.sv
// SCAN car scheduler for the 5-floor elevator.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : call pulses in, pending/floor/direction/strobe status out
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  elevator_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

  state_t     state, next_state;
  floor_t     cur_floor, next_floor;
  floor_vec_t pending, clr;
  floor_vec_t calls_above, calls_below, calls_beyond;
  logic       dir_up, next_dir;
  logic       moving, door_open, arrive;
  logic       step, door_call;
  logic       timer_load, timer_zero;
  logic [CNT_W-1:0] timer_val;

  elevator_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    next_state   = state;
    next_floor   = cur_floor;
    next_dir     = dir_up;
    step         = 1'b0;
    timer_load   = 1'b0;
    timer_val    = MOVE_LOAD;
    calls_beyond = '0;
    calls_above  = pending & above_mask(cur_floor);
    calls_below  = pending & below_mask(cur_floor);
    door_call    = |(bus.call_req & floor_onehot(cur_floor));

    case (state)
      IDLE: begin
        if (pending != '0) begin
          if (|(pending & floor_onehot(cur_floor))) begin
            next_state = DOOR;
            timer_load = 1'b1;
            timer_val  = DOOR_LOAD;
          // Keep direction if work lies ahead, otherwise reverse; with the
          // current floor excluded, "no call below" implies a call above.
          end else if ((dir_up && calls_above != '0) || (!dir_up && calls_below == '0)) begin
            next_state = MOVE_UP;
            next_dir   = 1'b1;
            timer_load = 1'b1;
          end else begin
            next_state = MOVE_DOWN;
            next_dir   = 1'b0;
            timer_load = 1'b1;
          end
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (timer_zero) begin
          step = 1'b1;
          if (state == MOVE_UP) begin
            next_floor   = cur_floor + 4'd1;
            calls_beyond = pending & above_mask(next_floor);
          end else begin
            next_floor   = cur_floor - 4'd1;
            calls_beyond = pending & below_mask(next_floor);
          end
          if (|(pending & floor_onehot(next_floor))) begin
            next_state = DOOR;
            timer_load = 1'b1;
            timer_val  = DOOR_LOAD;
          end else if (calls_beyond != '0) begin
            timer_load = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end

      DOOR: begin
        if (door_call) begin
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
        end else if (timer_zero) begin
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase

    // Clearing by the post-edge floor covers both the arrival edge and the
    // whole door period, so a call for the open floor is never latched.
    clr = (next_state == DOOR || state == DOOR) ? floor_onehot(next_floor) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_floor <= 4'd1;
      pending   <= '0;
      dir_up    <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
    end else begin
      state     <= next_state;
      cur_floor <= next_floor;
      pending   <= (pending | bus.call_req) & ~clr;
      dir_up    <= next_dir;
      moving    <= (next_state == MOVE_UP) || (next_state == MOVE_DOWN);
      door_open <= (next_state == DOOR);
      arrive    <= step;
    end
  end

  assign bus.pending   = pending;
  assign bus.cur_floor = cur_floor;
  assign bus.dir_up    = dir_up;
  assign bus.moving    = moving;
  assign bus.door_open = door_open;
  assign bus.arrive    = arrive;

endmodule
